// File: rtl/stopwatch_pkg.sv
// Shared types and elaboration-time helpers for the stopwatch timebase.
// Optional lap capture is enabled by defining STOPWATCH_LAP_CAPTURE_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int unsigned calc_presc_w(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decade counter: counts 0..9 on inc, asserts carry when wrapping 9 -> 0.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic       carry,
    output logic [3:0] value
);

    bcd_digit_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign carry = inc && (digit_q == BCD_MAX);
    assign value = digit_q;

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch core: prescaler to a fixed tick rate feeding a chain of BCD digits.
// Define STOPWATCH_LAP_CAPTURE_EN to build the lap-capture register.
module stopwatch_timebase
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 10,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    contar_tempo,
    input  logic                    zerar_tempo,
    input  logic                    lap_req,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    tick,
    output logic                    running,
    output logic                    ovf,
    output logic [4*NUM_DIGITS-1:0] lap_bcd,
    output logic                    lap_valid
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PW  = calc_presc_w(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    sw_state_t         state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_q, tick_d;
    logic              ovf_q, ovf_d;
    logic              running_q, running_d;
    logic              clr;
    logic [NUM_DIGITS:0] carry_chain;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clr     = 1'b0;
        if (zerar_tempo) begin
            state_d = StIdle;
            presc_d = '0;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StPause: begin
                    if (contar_tempo) state_d = StRun;
                end
                StRun: begin
                    if (!contar_tempo) state_d = StPause;
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        running_d = (state_d == StRun);
    end

    // Ripple enable: a digit increments only when every lower digit wraps.
    assign carry_chain[0] = tick_d;
    assign ovf_d          = carry_chain[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (carry_chain[i]),
            .carry (carry_chain[i+1]),
            .value (count_bcd[4*i +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
        end
    end

    assign tick    = tick_q;
    assign ovf     = ovf_q;
    assign running = running_q;

`ifdef STOPWATCH_LAP_CAPTURE_EN
    logic [4*NUM_DIGITS-1:0] lap_q;
    logic                    lap_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else if (zerar_tempo) begin
            lap_valid_q <= 1'b0;
        end else if (lap_req && (state_q != StIdle)) begin
            // count_bcd here is the pre-increment value on a tick cycle.
            lap_q       <= count_bcd;
            lap_valid_q <= 1'b1;
        end
    end

    assign lap_bcd   = lap_q;
    assign lap_valid = lap_valid_q;
`else
    logic unused_lap_req;
    assign unused_lap_req = lap_req;
    assign lap_bcd        = '0;
    assign lap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase with CLK_HZ=10, TICK_HZ=2 (DIV=5), two digits.
// Lap checks follow STOPWATCH_LAP_CAPTURE_EN.
module tb_stopwatch_timebase;

    logic       clk;
    logic       rst_n;
    logic       contar_tempo;
    logic       zerar_tempo;
    logic       lap_req;
    logic [7:0] count_bcd;
    logic       tick;
    logic       running;
    logic       ovf;
    logic [7:0] lap_bcd;
    logic       lap_valid;

    int total = 0;
    int bad   = 0;

    stopwatch_timebase #(
        .CLK_HZ     (10),
        .TICK_HZ    (2),
        .NUM_DIGITS (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .contar_tempo (contar_tempo),
        .zerar_tempo  (zerar_tempo),
        .lap_req      (lap_req),
        .count_bcd    (count_bcd),
        .tick         (tick),
        .running      (running),
        .ovf          (ovf),
        .lap_bcd      (lap_bcd),
        .lap_valid    (lap_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        contar_tempo = 1'b0;
        zerar_tempo  = 1'b0;
        lap_req      = 1'b0;
        step();
        step();
        check("rst_count", 32'(count_bcd), 32'h00);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_lap_valid", 32'(lap_valid), 32'd0);
        check("rst_lap_bcd", 32'(lap_bcd), 32'h00);

        // Run from IDLE: RUN at edge 1, ticks at edges 6, 11, 16, 21, 26.
        rst_n        = 1'b1;
        contar_tempo = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            step();
            check($sformatf("run_tick_c%0d", c), 32'(tick),
                  32'((c > 1) && (c % 5 == 1)));
            if (c == 1) check("run_running_edge1", 32'(running), 32'd1);
        end
        check("run_count_05", 32'(count_bcd), 32'h05);

        // 93 more ticks reach 0x98, one more 0x99, next wraps with ovf.
        for (int c = 0; c < 465; c++) step();
        check("count_98", 32'(count_bcd), 32'h98);
        check("tick_at_98", 32'(tick), 32'd1);
        for (int c = 0; c < 5; c++) step();
        check("count_99", 32'(count_bcd), 32'h99);
        check("ovf_not_at_99", 32'(ovf), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("wrap_ovf_c%0d", c), 32'(ovf), 32'(c == 5));
        end
        check("wrap_count_00", 32'(count_bcd), 32'h00);
        step();
        check("ovf_one_cycle", 32'(ovf), 32'd0);
        for (int c = 0; c < 4; c++) step();
        check("tick_after_wrap", 32'(tick), 32'd1);
        check("count_01", 32'(count_bcd), 32'h01);

        // Three RUN cycles past the tick (prescaler ends at 3), then pause.
        step();
        step();
        contar_tempo = 1'b0;
        step();
        check("pause_running", 32'(running), 32'd0);
        for (int c = 0; c < 19; c++) begin
            step();
            check($sformatf("pause_tick_c%0d", c), 32'(tick), 32'd0);
            check($sformatf("pause_running_c%0d", c), 32'(running), 32'd0);
        end
        check("pause_count_hold", 32'(count_bcd), 32'h01);
        contar_tempo = 1'b1;
        step();
        check("resume_running", 32'(running), 32'd1);
        check("resume_tick_edge0", 32'(tick), 32'd0);
        step();
        check("resume_tick_edge1", 32'(tick), 32'd0);
        step();
        check("resume_tick_edge2", 32'(tick), 32'd1);
        check("resume_count_02", 32'(count_bcd), 32'h02);

        // Clear on the cycle the prescaler sits at DIV-1.
        for (int c = 0; c < 4; c++) step();
        zerar_tempo = 1'b1;
        step();
        check("clr_no_tick", 32'(tick), 32'd0);
        check("clr_no_ovf", 32'(ovf), 32'd0);
        check("clr_count", 32'(count_bcd), 32'h00);
        check("clr_running", 32'(running), 32'd0);
        zerar_tempo = 1'b0;
        step();
        check("clr_restart_running", 32'(running), 32'd1);
        for (int c = 2; c <= 6; c++) begin
            step();
            check($sformatf("clr_restart_tick_c%0d", c), 32'(tick), 32'(c == 6));
        end
        check("clr_restart_count", 32'(count_bcd), 32'h01);

`ifdef STOPWATCH_LAP_CAPTURE_EN
        for (int c = 0; c < 55; c++) step();
        check("lap_pre_count", 32'(count_bcd), 32'h12);
        for (int c = 0; c < 4; c++) step();
        lap_req = 1'b1;
        step();
        lap_req = 1'b0;
        check("lap_tick", 32'(tick), 32'd1);
        check("lap_bcd_12", 32'(lap_bcd), 32'h12);
        check("lap_valid_set", 32'(lap_valid), 32'd1);
        check("lap_count_13", 32'(count_bcd), 32'h13);
        zerar_tempo = 1'b1;
        lap_req     = 1'b1;
        step();
        check("lap_clr_valid", 32'(lap_valid), 32'd0);
        contar_tempo = 1'b0;
        zerar_tempo  = 1'b0;
        step();
        check("lap_idle_ignored", 32'(lap_valid), 32'd0);
        lap_req = 1'b0;
`else
        lap_req = 1'b1;
        step();
        lap_req = 1'b0;
        step();
        check("nolap_bcd", 32'(lap_bcd), 32'h00);
        check("nolap_valid", 32'(lap_valid), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
